rom_fetch_sequencer: RTL and testbench

//  Reader side of the 64x34 instruction ROM: drives the ROM address, captures the

---
 rtl/rom_seq_pkg.sv | 22 ++
 rtl/rom_seq_next_pc.sv | 28 ++
 rtl/rom_fetch_sequencer.sv | 101 ++++++++++
 tb/tb_rom_fetch_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// Shared constants and types for the ROM fetch sequencer.
// The opcode occupies the top OP_W bits of every ROM word.
package rom_seq_pkg;

  localparam int OP_W  = 2;
  localparam int CNT_W = 8;

  localparam logic [OP_W-1:0] OP_NORMAL = 2'b00;
  localparam logic [OP_W-1:0] OP_RSVD   = 2'b01;
  localparam logic [OP_W-1:0] OP_JUMP   = 2'b10;
  localparam logic [OP_W-1:0] OP_HALT   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } state_e;

endpackage

// File: rtl/rom_seq_next_pc.sv
// Decodes an issued word into the address of the following fetch.
// The reserved opcode behaves exactly like a normal word.
module rom_seq_next_pc
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [OP_W-1:0]   opcode,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              is_halt
);

  always_comb begin
    next_pc = pc + ADDR_W'(1);
    is_halt = 1'b0;
    case (opcode)
      OP_JUMP: next_pc = target;
      OP_HALT: begin
        next_pc = pc;
        is_halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Reader side of the instruction ROM: walks the program, follows jumps, stops on
// halt, and hands each word to the consumer over a valid/ready handshake.
module rom_fetch_sequencer
  import rom_seq_pkg::*;
#(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 34,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  issued_cnt
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  next_pc;
  logic               is_halt;

  rom_seq_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc      (pc_q),
    .opcode  (instr_q[DATA_W-1:DATA_W-OP_W]),
    .target  (instr_q[ADDR_W-1:0]),
    .next_pc (next_pc),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // The held word decides where the walk goes only once the consumer has taken it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        instr_d = rom_data;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          pc_d    = next_pc;
          state_d = is_halt ? HALT : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == FETCH) || (state_q == HOLD);
    halted = (state_q == HALT);
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Randomized scoreboard bench for rom_fetch_sequencer: a program-walking model
// predicts every issued word, a negedge monitor compares each handshake.
module tb_rom_fetch_sequencer;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 34;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
    int                cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              instr_ready = 1'b0;
  logic [ADDR_W-1:0] rom_addr, pc;
  logic [DATA_W-1:0] rom_data, instr;
  logic              instr_valid, busy, halted;
  logic [7:0]        issued_cnt;

  logic              start63 = 1'b0;
  logic              ready63 = 1'b1;
  logic [ADDR_W-1:0] rom_addr63, pc63;
  logic [DATA_W-1:0] rom_data63, instr63;
  logic              instr_valid63, busy63, halted63;
  logic [7:0]        issued_cnt63;

  logic [DATA_W-1:0] rom_mem [64];
  exp_t              exp_q[$];
  exp_t              exp63_q[$];
  int                total = 0;
  int                bad = 0;
  int                ready_mode = 0;

  assign rom_data   = rom_mem[rom_addr];
  assign rom_data63 = rom_mem[rom_addr63];

  always #5 clk = ~clk;

  rom_fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR(6'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .busy(busy), .halted(halted), .issued_cnt(issued_cnt)
  );

  rom_fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR(6'd63)) u_dut63 (
    .clk(clk), .rst_n(rst_n), .start(start63), .rom_addr(rom_addr63), .rom_data(rom_data63),
    .instr(instr63), .instr_valid(instr_valid63), .instr_ready(ready63), .pc(pc63),
    .busy(busy63), .halted(halted63), .issued_cnt(issued_cnt63)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Bench program: 0,1,5,63 normal (random reserved/normal opcode), 2 jumps to 5, 6 halts.
  task automatic build_rom();
    for (int a = 0; a < 64; a++) rom_mem[a] = {2'($urandom), 32'($urandom)};
    rom_mem[0]  = {1'b0, 1'($urandom), 32'($urandom)};
    rom_mem[1]  = {1'b0, 1'($urandom), 32'($urandom)};
    rom_mem[5]  = {1'b0, 1'($urandom), 32'($urandom)};
    rom_mem[63] = {1'b0, 1'($urandom), 32'($urandom)};
    rom_mem[2]  = {2'b10, 26'($urandom), 6'd5};
    rom_mem[6]  = {2'b11, 32'($urandom)};
  endtask

  // Reference model: walk the program as the consumer will see it.
  task automatic walk(input logic [ADDR_W-1:0] from, input int max_n, input bit to63);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] w;
    exp_t e;
    a = from;
    for (int i = 0; i < max_n; i++) begin
      w = rom_mem[a];
      e.pc = a;
      e.word = w;
      e.cnt = (i > 255) ? 255 : i;
      if (to63) exp63_q.push_back(e);
      else exp_q.push_back(e);
      if (w[DATA_W-1:DATA_W-2] == 2'b11) break;
      else if (w[DATA_W-1:DATA_W-2] == 2'b10) a = w[ADDR_W-1:0];
      else a = ADDR_W'((int'(a) + 1) % 64);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: instr_ready = 1'b1;
      1: instr_ready = 1'($urandom_range(0, 1));
      default: instr_ready = 1'b0;
    endcase
  endtask

  task automatic applyStimulus(input bit takes_effect, input int max_n);
    start = 1'b1;
    if (takes_effect) walk(6'd0, max_n, 1'b0);
    step();
    start = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      step();
      n++;
    end
    checkOutput("halt_reached", halted, 1);
  endtask

  task automatic wait_valid_at(input logic [ADDR_W-1:0] addr, input int budget);
    int n = 0;
    while (!(instr_valid && pc == addr) && n < budget) begin
      step();
      n++;
    end
    checkOutput("valid_at_pc", {instr_valid, pc}, {1'b1, addr});
  endtask

  task automatic check_halt_state(input int cnt);
    checkOutput("halted", halted, 1);
    checkOutput("busy_in_halt", busy, 0);
    checkOutput("valid_in_halt", instr_valid, 0);
    checkOutput("issued_total", issued_cnt, cnt);
    checkOutput("sb_drained", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) checkOutput("sb_pending", 0, 1);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("instr", instr, e.word);
        checkOutput("pc", pc, e.pc);
        checkOutput("rom_addr", rom_addr, e.pc);
        checkOutput("issued_cnt", issued_cnt, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && instr_valid63 && ready63) begin
      if (exp63_q.size() == 0) checkOutput("sb63_pending", 0, 1);
      else begin
        exp_t e;
        e = exp63_q.pop_front();
        checkOutput("instr63", instr63, e.word);
        checkOutput("pc63", pc63, e.pc);
        checkOutput("issued_cnt63", issued_cnt63, e.cnt);
      end
    end
  end

  initial begin
    build_rom();
    #12;
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_cnt", issued_cnt, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_pc63", pc63, 63);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Straight program run, first with ready tied high, then with random back-pressure.
    for (int it = 0; it < 3; it++) begin
      build_rom();
      ready_mode = (it == 0) ? 0 : 1;
      applyStimulus(1'b1, 64);
      wait_halted(400);
      check_halt_state(5);
    end

    // Consumer stalls while the word from address 1 is held.
    ready_mode = 2;
    applyStimulus(1'b1, 64);
    wait_valid_at(6'd0, 20);
    instr_ready = 1'b1;
    step();
    wait_valid_at(6'd1, 20);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("stall_instr", instr, rom_mem[1]);
      checkOutput("stall_pc", pc, 1);
      checkOutput("stall_valid", instr_valid, 1);
    end
    instr_ready = 1'b1;
    step();
    checkOutput("after_stall_pc", pc, 2);
    checkOutput("after_stall_valid", instr_valid, 0);
    ready_mode = 0;
    wait_halted(400);
    check_halt_state(5);

    // Restart from HALT clears the count; start while running is ignored.
    ready_mode = 1;
    applyStimulus(1'b1, 64);
    checkOutput("restart_cnt", issued_cnt, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_halted", halted, 0);
    for (int i = 0; i < 3; i++) begin
      if (busy) applyStimulus(1'b0, 0);
      step();
    end
    wait_halted(400);
    check_halt_state(5);

    // Start at the top address: wrap from 63 to 0.
    walk(6'd63, 64, 1'b1);
    start63 = 1'b1;
    step();
    start63 = 1'b0;
    begin
      int n = 0;
      while (!halted63 && n < 400) begin
        step();
        n++;
      end
    end
    checkOutput("halted63", halted63, 1);
    checkOutput("issued_cnt63_total", issued_cnt63, 6);
    checkOutput("sb63_drained", exp63_q.size(), 0);

    // Self-jump loop saturates the issue counter.
    rom_mem[0] = {2'b10, 26'($urandom), 6'd0};
    ready_mode = 0;
    applyStimulus(1'b1, 260);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        step();
        n++;
      end
    end
    instr_ready = 1'b0;
    ready_mode = 2;
    checkOutput("loop_drained", exp_q.size(), 0);
    step();
    checkOutput("sat_cnt", issued_cnt, 255);
    checkOutput("loop_busy", busy, 1);
    checkOutput("pre_reset_valid", instr_valid, 1);

    // Asynchronous reset while a word is held.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", instr_valid, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_halted", halted, 0);
    checkOutput("async_rst_pc", pc, 0);
    checkOutput("async_rst_addr", rom_addr, 0);
    checkOutput("async_rst_cnt", issued_cnt, 0);
    checkOutput("async_rst_instr", instr, 0);
    checkOutput("async_rst_halted63", halted63, 0);
    exp_q.delete();
    exp63_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
